// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory block port between the icache and
// dcache miss handlers. Grants one block transfer at a time, breaks ties
// round-robin, and sequences the strobe / busy-wait / read-data return.
module mem_arbiter #(
   parameter int ADDR_W  = 6,
   parameter int BLOCK_W = 32
) (
   input  logic               CLK,
   input  logic               RESET,
   // icache port
   input  logic               i_read,
   input  logic [ADDR_W-1:0]  i_address,
   output logic [BLOCK_W-1:0] i_readdata,
   output logic               i_busywait,
   // dcache port
   input  logic               d_read,
   input  logic               d_write,
   input  logic [ADDR_W-1:0]  d_address,
   input  logic [BLOCK_W-1:0] d_writedata,
   output logic [BLOCK_W-1:0] d_readdata,
   output logic               d_busywait,
   // memory port
   output logic               mem_read,
   output logic               mem_write,
   output logic [ADDR_W-1:0]  mem_address,
   output logic [BLOCK_W-1:0] mem_writedata,
   input  logic [BLOCK_W-1:0] mem_readdata,
   input  logic               mem_busywait
);

   typedef enum logic [1:0] {IDLE, GRANT, XFER, DONE} state_t;

   localparam logic OWN_I = 1'b0;
   localparam logic OWN_D = 1'b1;

   state_t             state;
   logic               owner;
   logic               last_grant;
   logic               op_write;
   logic [ADDR_W-1:0]  addr_hold;
   logic [BLOCK_W-1:0] wdata_hold;

   logic               req_i, req_d;
   logic               nxt_owner, nxt_op_write;
   logic               active;
   logic [ADDR_W-1:0]  sel_addr;
   logic [BLOCK_W-1:0] sel_wdata;

   assign req_i  = i_read;
   assign req_d  = d_read | d_write;
   assign active = (state == GRANT) || (state == XFER);

   // Pick the next owner from IDLE: sole requester, or on a tie the one not served last.
   always_comb begin
      nxt_owner = OWN_I;
      if (req_i && req_d) nxt_owner = ~last_grant;
      else if (req_d)     nxt_owner = OWN_D;
      // d_read together with d_write is a write-back
      nxt_op_write = (nxt_owner == OWN_D) ? d_write : 1'b0;
   end

   // Address/data follow the owner's inputs live; the icache never writes,
   // so an icache transfer simply keeps the previous write data.
   assign sel_addr  = (owner == OWN_D) ? d_address : i_address;
   assign sel_wdata = (owner == OWN_D) ? d_writedata : wdata_hold;

   assign mem_address   = active ? sel_addr  : addr_hold;
   assign mem_writedata = active ? sel_wdata : wdata_hold;

   // A requester stalls from its first request cycle until its own DONE cycle.
   assign i_busywait = ~RESET & req_i & ~((state == DONE) && (owner == OWN_I));
   assign d_busywait = ~RESET & req_d & ~((state == DONE) && (owner == OWN_D));

   // Transfer sequencer: owner/op latched at GRANT entry, strobes registered.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state      <= IDLE;
         owner      <= OWN_I;
         last_grant <= OWN_D;
         op_write   <= 1'b0;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         i_readdata <= '0;
         d_readdata <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_i || req_d) begin
                  owner     <= nxt_owner;
                  op_write  <= nxt_op_write;
                  mem_read  <= ~nxt_op_write;
                  mem_write <= nxt_op_write;
                  state     <= GRANT;
               end
            end
            GRANT: begin
               if (mem_busywait) state <= XFER;
            end
            XFER: begin
               if (!mem_busywait) begin
                  if (!op_write) begin
                     if (owner == OWN_I) i_readdata <= mem_readdata;
                     else                d_readdata <= mem_readdata;
                  end
                  last_grant <= owner;
                  mem_read   <= 1'b0;
                  mem_write  <= 1'b0;
                  state      <= DONE;
               end
            end
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   // Remember the last driven address/data so they hold outside a transfer.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         addr_hold  <= '0;
         wdata_hold <= '0;
      end else if (active) begin
         addr_hold  <= sel_addr;
         wdata_hold <= sel_wdata;
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus with a scoreboard. Stimulus pushes the
// expected memory command and the expected completion; a negedge monitor pops
// and compares whenever a strobe rises or a requester's busywait drops.
module tb_mem_arbiter;
   localparam int AW = 6;
   localparam int BW = 32;

   logic          CLK = 1'b0;
   logic          RESET;
   logic          i_read, d_read, d_write;
   logic [AW-1:0] i_address, d_address;
   logic [BW-1:0] d_writedata;
   logic [BW-1:0] i_readdata, d_readdata;
   logic          i_busywait, d_busywait;
   logic          mem_read, mem_write;
   logic [AW-1:0] mem_address;
   logic [BW-1:0] mem_writedata;
   logic [BW-1:0] mem_readdata;
   logic          mem_busywait;

   mem_arbiter #(.ADDR_W(AW), .BLOCK_W(BW)) dut (
      .CLK(CLK), .RESET(RESET),
      .i_read(i_read), .i_address(i_address), .i_readdata(i_readdata), .i_busywait(i_busywait),
      .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_writedata(d_writedata),
      .d_readdata(d_readdata), .d_busywait(d_busywait),
      .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
      .mem_writedata(mem_writedata), .mem_readdata(mem_readdata), .mem_busywait(mem_busywait)
   );

   always #5 CLK = ~CLK;

   typedef struct { logic wr; logic [AW-1:0] addr; logic [BW-1:0] wdata; } mem_exp_t;
   typedef struct { logic is_d; logic [BW-1:0] rdata; } done_exp_t;

   mem_exp_t  exp_mem[$];
   done_exp_t exp_done[$];
   int checks = 0;
   int errors = 0;
   logic [BW-1:0] d_last = '0;

   // Memory model: 5 busy cycles per transfer, waits for the strobe to drop before the next one.
   logic [BW-1:0] mem_arr [64];
   int            m_st, m_cnt;
   logic [AW-1:0] m_addr;
   always @(posedge CLK) begin
      if (RESET) begin
         for (int k = 0; k < 64; k++) mem_arr[k] <= '0;
         mem_arr[6'h05] <= 32'hDEADBEEF;
         mem_arr[6'h0A] <= 32'hCAFEF00D;
         mem_arr[6'h07] <= 32'hA5A5A5A5;
         mem_arr[6'h11] <= 32'h0BADF00D;
         m_st <= 0; m_cnt <= 0; m_addr <= '0;
         mem_busywait <= 1'b0;
         mem_readdata <= '0;
      end else begin
         case (m_st)
            0: if (mem_read | mem_write) begin
                  mem_busywait <= 1'b1;
                  m_cnt  <= 5;
                  m_addr <= mem_address;
                  if (mem_write) mem_arr[mem_address] <= mem_writedata;
                  m_st <= 1;
               end
            1: if (m_cnt == 1) begin
                  mem_busywait <= 1'b0;
                  mem_readdata <= mem_arr[m_addr];
                  m_st <= 2;
               end else m_cnt <= m_cnt - 1;
            default: if (!(mem_read | mem_write)) m_st <= 0;
         endcase
      end
   end

   // Monitor: pops and compares on strobe rise and on each requester's DONE cycle.
   logic      prev_strobe = 1'b0;
   mem_exp_t  me;
   done_exp_t de;
   always @(negedge CLK) begin
      if (!RESET) begin
         checks++;
         if (mem_read && mem_write) begin
            errors++; $display("FAIL strobe_overlap: mem_read=%b mem_write=%b, required one-hot", mem_read, mem_write);
         end
         checks++;
         if ((d_busywait && !(d_read | d_write)) || (i_busywait && !i_read)) begin
            errors++; $display("FAIL busywait_no_req: i_bw=%b d_bw=%b, required 0 without request", i_busywait, d_busywait);
         end
         if ((mem_read | mem_write) && !prev_strobe) begin
            checks++;
            if (exp_mem.size() == 0) begin
               errors++; $display("FAIL mem_cmd: unexpected strobe rd=%b wr=%b addr=%h", mem_read, mem_write, mem_address);
            end else begin
               me = exp_mem.pop_front();
               if (mem_write !== me.wr || mem_read !== !me.wr || mem_address !== me.addr ||
                   (me.wr && mem_writedata !== me.wdata)) begin
                  errors++;
                  $display("FAIL mem_cmd: got rd=%b wr=%b addr=%h wdata=%h, required wr=%b addr=%h wdata=%h",
                           mem_read, mem_write, mem_address, mem_writedata, me.wr, me.addr, me.wdata);
               end
            end
         end
         if (i_read && !i_busywait) begin
            checks++;
            if (exp_done.size() == 0) begin
               errors++; $display("FAIL done_i: unexpected icache completion");
            end else begin
               de = exp_done.pop_front();
               if (de.is_d !== 1'b0 || i_readdata !== de.rdata) begin
                  errors++; $display("FAIL done_i: got icache rdata=%h, required owner_d=%b rdata=%h", i_readdata, de.is_d, de.rdata);
               end
            end
         end
         if ((d_read | d_write) && !d_busywait) begin
            checks++;
            if (exp_done.size() == 0) begin
               errors++; $display("FAIL done_d: unexpected dcache completion");
            end else begin
               de = exp_done.pop_front();
               if (de.is_d !== 1'b1 || d_readdata !== de.rdata) begin
                  errors++; $display("FAIL done_d: got dcache rdata=%h, required owner_d=%b rdata=%h", d_readdata, de.is_d, de.rdata);
               end
            end
         end
      end
      prev_strobe = RESET ? 1'b0 : (mem_read | mem_write);
   end

   task automatic i_req(input logic [AW-1:0] a);
      int n = 0;
      i_read = 1'b1; i_address = a;
      do begin @(negedge CLK); n++; end while (i_busywait && n < 300);
      if (i_busywait) begin
         checks++; errors++; $display("FAIL i_timeout: busywait still %b after %0d cycles, required 0", i_busywait, n);
      end
      @(posedge CLK); #1 i_read = 1'b0;
   endtask

   task automatic d_req(input logic rd, input logic wr, input logic [AW-1:0] a, input logic [BW-1:0] wd);
      int n = 0;
      d_read = rd; d_write = wr; d_address = a; d_writedata = wd;
      do begin @(negedge CLK); n++; end while (d_busywait && n < 300);
      if (d_busywait) begin
         checks++; errors++; $display("FAIL d_timeout: busywait still %b after %0d cycles, required 0", d_busywait, n);
      end
      @(posedge CLK); #1 begin d_read = 1'b0; d_write = 1'b0; end
   endtask

   task automatic chk(input string name, input logic [BW-1:0] got, input logic [BW-1:0] req);
      checks++;
      if (got !== req) begin
         errors++; $display("FAIL %s: got %h, required %h", name, got, req);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      RESET = 1'b1; i_read = 0; d_read = 0; d_write = 0;
      i_address = '0; d_address = '0; d_writedata = '0;
      repeat (2) @(posedge CLK);
      #1 RESET = 1'b0;
      @(negedge CLK);
      chk("rst_mem_read",  {31'b0, mem_read}, 32'h0);
      chk("rst_mem_write", {31'b0, mem_write}, 32'h0);
      chk("rst_mem_addr",  {26'b0, mem_address}, 32'h0);
      chk("rst_mem_wdata", mem_writedata, 32'h0);
      chk("rst_readdata",  i_readdata | d_readdata, 32'h0);

      // single icache read
      @(posedge CLK); #1;
      exp_mem.push_back('{1'b0, 6'h05, '0});
      exp_done.push_back('{1'b0, 32'hDEADBEEF});
      i_req(6'h05);

      // dcache write-back leaves d_readdata alone
      @(posedge CLK); #1;
      exp_mem.push_back('{1'b1, 6'h3F, 32'h12345678});
      exp_done.push_back('{1'b1, d_last});
      d_req(1'b0, 1'b1, 6'h3F, 32'h12345678);

      // read and write together: a write
      @(posedge CLK); #1;
      exp_mem.push_back('{1'b1, 6'h3F, 32'h55AA55AA});
      exp_done.push_back('{1'b1, d_last});
      d_req(1'b1, 1'b1, 6'h3F, 32'h55AA55AA);

      // tie with last_grant=D: icache first, then dcache
      @(posedge CLK); #1;
      exp_mem.push_back('{1'b0, 6'h0A, '0});
      exp_mem.push_back('{1'b0, 6'h3F, '0});
      exp_done.push_back('{1'b0, 32'hCAFEF00D});
      exp_done.push_back('{1'b1, 32'h55AA55AA});
      d_last = 32'h55AA55AA;
      fork i_req(6'h0A); d_req(1'b1, 1'b0, 6'h3F, '0); join

      // repeat tie: icache again
      @(posedge CLK); #1;
      exp_mem.push_back('{1'b0, 6'h05, '0});
      exp_mem.push_back('{1'b0, 6'h11, '0});
      exp_done.push_back('{1'b0, 32'hDEADBEEF});
      exp_done.push_back('{1'b1, 32'h0BADF00D});
      d_last = 32'h0BADF00D;
      fork i_req(6'h05); d_req(1'b1, 1'b0, 6'h11, '0); join

      // back-to-back: dcache arrives during icache XFER
      @(posedge CLK); #1;
      exp_mem.push_back('{1'b0, 6'h07, '0});
      exp_mem.push_back('{1'b0, 6'h0A, '0});
      exp_done.push_back('{1'b0, 32'hA5A5A5A5});
      exp_done.push_back('{1'b1, 32'hCAFEF00D});
      d_last = 32'hCAFEF00D;
      fork
         i_req(6'h07);
         begin repeat (4) @(posedge CLK); #1 d_req(1'b1, 1'b0, 6'h0A, '0); end
      join

      // RESET in the middle of an icache XFER
      @(posedge CLK); #1;
      exp_mem.push_back('{1'b0, 6'h05, '0});
      i_read = 1'b1; i_address = 6'h05;
      n = 0;
      do begin @(negedge CLK); n++; end while (!mem_busywait && n < 50);
      checks++;
      if (!mem_busywait) begin errors++; $display("FAIL xfer_reach: mem_busywait=%b, required 1", mem_busywait); end
      repeat (2) @(negedge CLK);
      @(posedge CLK); #1 RESET = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      chk("midrst_strobe", {30'b0, mem_read, mem_write}, 32'h0);
      chk("midrst_busy",   {30'b0, i_busywait, d_busywait}, 32'h0);
      chk("midrst_i_rd",   i_readdata, 32'h0);
      chk("midrst_d_rd",   d_readdata, 32'h0);
      chk("midrst_addr",   {26'b0, mem_address}, 32'h0);
      @(posedge CLK); #1 begin RESET = 1'b0; i_read = 1'b0; end
      d_last = '0;

      // after reset last_grant is D again: tie goes to icache
      @(posedge CLK); #1;
      exp_mem.push_back('{1'b0, 6'h11, '0});
      exp_mem.push_back('{1'b0, 6'h07, '0});
      exp_done.push_back('{1'b0, 32'h0BADF00D});
      exp_done.push_back('{1'b1, 32'hA5A5A5A5});
      fork i_req(6'h11); d_req(1'b1, 1'b0, 6'h07, '0); join

      repeat (3) @(posedge CLK);
      chk("left_mem_exp",  exp_mem.size(), 32'h0);
      chk("left_done_exp", exp_done.size(), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
